// File: rtl/fx_pkg.sv
// Shared fixed-point math constants, divider FSM states and saturation limits.
package fx_pkg;

    localparam int FX_WIDTH = 32;
    localparam int FX_QINT  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } fx_state_e;

    function automatic logic [63:0] fx_max(int width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] fx_min(int width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/fx_div_if.sv
// Start/done pulse handshake bundle for fx_div, plus a debug view of the FSM state.
interface fx_div_if
    import fx_pkg::*;
#(
    parameter int WIDTH = FX_WIDTH
);
    // start is a one-cycle request taken only when busy is low; done is a one-cycle
    // completion pulse with result/ovf/dbz valid; result holds until the next done.
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic [WIDTH-1:0] result;
    logic             done;
    logic             ovf;
    logic             dbz;
    fx_state_e        dbg_state;

    modport master (output start, a, b, input busy, result, done, ovf, dbz, dbg_state);
    modport slave  (input start, a, b, output busy, result, done, ovf, dbz, dbg_state);
endinterface

// File: rtl/fx_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, subtract if it fits.
module fx_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    // The true difference is below 2^WIDTH whenever it is taken, so modulo arithmetic is exact.
    always_comb begin
        shifted = {rem_in, dvd_bit};
        q_bit   = (shifted >= {1'b0, divisor});
        diff    = shifted[WIDTH-1:0] - divisor;
        rem_out = q_bit ? diff : shifted[WIDTH-1:0];
    end
endmodule

// File: rtl/fx_div.sv
// Iterative signed Q-format divider, one quotient bit per cycle.
// Define FX_DIV_SAT_EN to saturate on overflow instead of wrapping.
module fx_div
    import fx_pkg::*;
#(
    parameter int WIDTH = FX_WIDTH,
    parameter int QINT  = FX_QINT
) (
    input logic     clk,
    input logic     rst_n,
    fx_div_if.slave dif
);
    localparam int QFRAC = WIDTH - QINT;
    localparam int N     = WIDTH + QFRAC;
    localparam int CW    = $clog2(N + 1);

    localparam logic [63:0]      MAX64   = fx_max(WIDTH);
    localparam logic [63:0]      MIN64   = fx_min(WIDTH);
    localparam logic [WIDTH-1:0] RES_MAX = MAX64[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RES_MIN = MIN64[WIDTH-1:0];
    localparam logic [N-1:0]     POS_LIM = {{(N-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic [N-1:0]     NEG_LIM = {{(N-WIDTH){1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

    fx_state_e        state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [N-1:0]     dvd_q, dvd_d;
    logic [N-1:0]     quo_q, quo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic             sign_q, sign_d;
    logic             zdiv_q, zdiv_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] step_rem;
    logic             step_bit;
    logic [WIDTH-1:0] wrap_res;
    logic             ovf_cond;

    function automatic logic [WIDTH-1:0] abs_val(logic [WIDTH-1:0] x);
        // The most negative value maps onto itself, which is its exact unsigned magnitude.
        return x[WIDTH-1] ? (~x + 1'b1) : x;
    endfunction

    fx_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_q),
        .dvd_bit (dvd_q[N-1]),
        .divisor (div_q),
        .rem_out (step_rem),
        .q_bit   (step_bit)
    );

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        dvd_d    = dvd_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        sign_d   = sign_q;
        zdiv_d   = zdiv_q;
        result_d = result_q;
        done_d   = 1'b0;
        ovf_d    = 1'b0;
        dbz_d    = 1'b0;
        wrap_res = sign_q ? (~quo_q[WIDTH-1:0] + 1'b1) : quo_q[WIDTH-1:0];
        ovf_cond = sign_q ? (quo_q > NEG_LIM) : (quo_q > POS_LIM);

        case (state_q)
            IDLE: begin
                if (dif.start) begin
                    sign_d  = dif.a[WIDTH-1] ^ dif.b[WIDTH-1];
                    zdiv_d  = (dif.b == '0);
                    div_d   = abs_val(dif.b);
                    dvd_d   = {abs_val(dif.a), {QFRAC{1'b0}}};
                    rem_d   = '0;
                    quo_d   = '0;
                    cnt_d   = CW'(N);
                    state_d = CALC;
                end
            end
            CALC: begin
                rem_d = step_rem;
                dvd_d = {dvd_q[N-2:0], 1'b0};
                quo_d = {quo_q[N-2:0], step_bit};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                if (zdiv_q) begin
                    // b was zero, so sign_q is just the sign of a.
                    result_d = sign_q ? RES_MIN : RES_MAX;
                    dbz_d    = 1'b1;
                end else begin
                    ovf_d = ovf_cond;
`ifdef FX_DIV_SAT_EN
                    result_d = ovf_cond ? (sign_q ? RES_MIN : RES_MAX) : wrap_res;
`else
                    result_d = wrap_res;
`endif
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            dvd_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            div_q    <= '0;
            sign_q   <= 1'b0;
            zdiv_q   <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            dvd_q    <= dvd_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            sign_q   <= sign_d;
            zdiv_q   <= zdiv_d;
            result_q <= result_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            dbz_q    <= dbz_d;
        end
    end

    assign dif.busy      = (state_q != IDLE);
    assign dif.result    = result_q;
    assign dif.done      = done_q;
    assign dif.ovf       = ovf_q;
    assign dif.dbz       = dbz_q;
    assign dif.dbg_state = state_q;
endmodule

// File: tb/tb_fx_div.sv
// Directed bench for fx_div: integer-arithmetic model, per-cycle compare of all outputs.
module tb_fx_div;
    import fx_pkg::*;

    localparam int LAT = 49;

    typedef struct {
        int          acc;
        int          due;
        logic [31:0] res;
        logic        ovf;
        logic        dbz;
        bit          cancelled;
    } op_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    fx_div_if #(.WIDTH(32)) dif ();

    fx_div dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dif   (dif)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    op_t         ops[64];
    int          n_ops    = 0;
    int          last_due = 0;
    int          rst_edge = -1;
    bit          chk_en   = 1'b0;

    int          rd       = 0;
    logic [31:0] hold     = '0;
    bit          pinned   = 1'b0;
    int          total    = 0;
    int          bad      = 0;

    // Expected outcome from plain integer division of the magnitudes.
    function automatic logic [33:0] model(logic [31:0] ta, logic [31:0] tb_v);
        longint sa, sb, ma, mb, q, sq;
        logic   sgn, o;
        logic [31:0] r;
        if (tb_v == 32'd0)
            return {(ta[31] ? 32'h8000_0000 : 32'h7FFF_FFFF), 1'b0, 1'b1};
        sa  = longint'($signed(ta));
        sb  = longint'($signed(tb_v));
        ma  = (sa < 0) ? -sa : sa;
        mb  = (sb < 0) ? -sb : sb;
        sgn = (sa < 0) ^ (sb < 0);
        q   = (ma <<< 16) / mb;
        o   = sgn ? (q > 64'sh8000_0000) : (q > 64'sh7FFF_FFFF);
        sq  = sgn ? -q : q;
        r   = sq[31:0];
`ifdef FX_DIV_SAT_EN
        if (o) r = sgn ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        return {r, o, 1'b0};
    endfunction

    task automatic chk(string name, logic [33:0] act, logic [33:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    always @(negedge clk) begin
        bit e_done, e_busy;
        if (chk_en) begin
            if (!pinned) begin
                pinned = 1'b1;
                chk("pin_3_div_2",  model(32'h0003_0000, 32'h0002_0000), {32'h0001_8000, 2'b00});
                chk("pin_m1_div_4", model(32'hFFFF_0000, 32'h0004_0000), {32'hFFFF_C000, 2'b00});
                chk("pin_1_div_3",  model(32'h0001_0000, 32'h0003_0000), {32'h0000_5555, 2'b00});
`ifdef FX_DIV_SAT_EN
                chk("pin_ovf",      model(32'h7FFF_0000, 32'h0000_0001), {32'h7FFF_FFFF, 2'b10});
`else
                chk("pin_ovf",      model(32'h7FFF_0000, 32'h0000_0001), {32'h0000_0000, 2'b10});
`endif
                chk("pin_dbz_pos",  model(32'h0005_0000, 32'h0000_0000), {32'h7FFF_FFFF, 2'b01});
                chk("pin_dbz_neg",  model(32'hFFFB_0000, 32'h0000_0000), {32'h8000_0000, 2'b01});
            end
            while (rd < n_ops && ops[rd].cancelled) rd++;
            if (edge_n == rst_edge) hold = '0;
            e_done = (rd < n_ops) && (edge_n == ops[rd].due);
            e_busy = (rd < n_ops) && (edge_n >= ops[rd].acc) && (edge_n < ops[rd].due);
            chk("done", {33'd0, dif.done}, {33'd0, e_done});
            chk("busy", {33'd0, dif.busy}, {33'd0, e_busy});
            if (e_done) begin
                hold = ops[rd].res;
                chk("result", {dif.result, dif.ovf, dif.dbz}, {ops[rd].res, ops[rd].ovf, ops[rd].dbz});
                rd++;
            end else begin
                chk("idle_out", {dif.result, dif.ovf, dif.dbz}, {hold, 2'b00});
            end
        end
    end

    task automatic start_op(input logic [31:0] ta, input logic [31:0] tb_v);
        int k;
        logic [33:0] m;
        @(negedge clk);
        #1;
        dif.a     = ta;
        dif.b     = tb_v;
        dif.start = 1'b1;
        k = edge_n + 1;
        if (k > last_due) begin
            m = model(ta, tb_v);
            ops[n_ops] = '{acc: k, due: k + LAT, res: m[33:2], ovf: m[1], dbz: m[0], cancelled: 1'b0};
            n_ops++;
            last_due = k + LAT;
        end
        @(posedge clk);
        #1;
        dif.start = 1'b0;
        dif.a     = $urandom;
        dif.b     = $urandom;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n    = 1'b0;
        rst_edge = edge_n + 1;
        if (n_ops > 0 && ops[n_ops-1].due >= rst_edge) ops[n_ops-1].cancelled = 1'b1;
        if (last_due < rst_edge) last_due = rst_edge;
        else last_due = rst_edge;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_idle();
        repeat (last_due - edge_n + 3) @(posedge clk);
        #1;
    endtask

    initial begin
        dif.start = 1'b0;
        dif.a     = '0;
        dif.b     = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);

        start_op(32'h0003_0000, 32'h0002_0000); wait_idle();
        start_op(32'hFFFF_0000, 32'h0004_0000); wait_idle();
        start_op(32'h0001_0000, 32'h0003_0000); wait_idle();
        start_op(32'h7FFF_0000, 32'h0000_0001); wait_idle();
        start_op(32'h0005_0000, 32'h0000_0000); wait_idle();
        start_op(32'hFFFB_0000, 32'h0000_0000); wait_idle();
        start_op(32'h8000_0000, 32'hFFFF_0000); wait_idle();
        start_op(32'h8000_0000, 32'h0001_0000); wait_idle();
        start_op(32'h0006_4000, 32'hFFFE_8000); wait_idle();
        start_op(32'hFFF9_0000, 32'hFFFC_0000); wait_idle();

        // Second start while busy must be dropped.
        start_op(32'h000A_0000, 32'h0004_0000);
        repeat (5) @(posedge clk);
        start_op(32'h0001_0000, 32'h0007_0000);
        // Start in the done cycle must be accepted.
        while (edge_n < last_due) begin
            @(posedge clk);
            #1;
        end
        start_op(32'hFFFE_0000, 32'h0003_0000);
        wait_idle();

        // Reset sampled on the 20th step, then a fresh division.
        start_op(32'h0009_0000, 32'h0002_0000);
        repeat (19) @(posedge clk);
        do_reset();
        repeat (60) @(posedge clk);
        start_op(32'h0009_0000, 32'h0002_0000); wait_idle();

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
